// File: rtl/tlc_pkg.sv
// Shared types and encodings for the traffic-light lamp monitor.
// Holds the FSM state enum, the fault codes and the cur_light encodings.
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_RED,
    ST_GREEN,
    ST_YELLOW,
    ST_FAULT
  } state_t;

  typedef enum logic [2:0] {
    CL_DARK,
    CL_CONF,
    CL_R,
    CL_G,
    CL_Y
  } lamp_cls_t;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_DARK     = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_SEQ      = 3'd3;
  localparam logic [2:0] FC_SHORT    = 3'd4;
  localparam logic [2:0] FC_LONG     = 3'd5;

  localparam logic [1:0] LT_NONE   = 2'd0;
  localparam logic [1:0] LT_RED    = 2'd1;
  localparam logic [1:0] LT_GREEN  = 2'd2;
  localparam logic [1:0] LT_YELLOW = 2'd3;

  function automatic lamp_cls_t classify(input logic r, input logic y, input logic g);
    case ({r, y, g})
      3'b000:  classify = CL_DARK;
      3'b100:  classify = CL_R;
      3'b010:  classify = CL_Y;
      3'b001:  classify = CL_G;
      default: classify = CL_CONF;
    endcase
  endfunction

  function automatic logic [1:0] light_of(input state_t s);
    case (s)
      ST_RED:    light_of = LT_RED;
      ST_GREEN:  light_of = LT_GREEN;
      ST_YELLOW: light_of = LT_YELLOW;
      default:   light_of = LT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tlc_dwell_cnt.sv
// Dwell counter for the lamp monitor: clear, load-to-1 on a lamp change,
// increment while the same lamp is held. Clear wins over load, load over inc.
module tlc_dwell_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load1,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_cnt <= '0;
    else if (i_clr)   r_cnt <= '0;
    else if (i_load1) r_cnt <= CNT_W'(1);
    else if (i_inc)   r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/tlc_monitor.sv
// Passive checker on the controller's lamp outputs: encoding, R->G->Y order
// and per-lamp dwell windows. First violation is latched until rst/clr_fault.
import tlc_pkg::*;

module tlc_monitor #(
  parameter int RED_MIN = 4,
  parameter int RED_MAX = 10,
  parameter int GRN_MIN = 4,
  parameter int GRN_MAX = 10,
  parameter int YEL_MIN = 1,
  parameter int YEL_MAX = 4,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] cur_light,
  output logic [7:0] cycles_ok
);

  // Timeout fires at MAX+1, so MAX+1 must still be representable.
  if (RED_MAX > 2**CNT_W - 2 || GRN_MAX > 2**CNT_W - 2 || YEL_MAX > 2**CNT_W - 2) begin : g_cnt_w_chk
    $error("tlc_monitor: CNT_W too small for the configured *_MAX");
  end

  localparam logic [CNT_W-1:0] R_MIN = CNT_W'(RED_MIN);
  localparam logic [CNT_W-1:0] R_MAX = CNT_W'(RED_MAX);
  localparam logic [CNT_W-1:0] G_MIN = CNT_W'(GRN_MIN);
  localparam logic [CNT_W-1:0] G_MAX = CNT_W'(GRN_MAX);
  localparam logic [CNT_W-1:0] Y_MIN = CNT_W'(YEL_MIN);
  localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(YEL_MAX);

  state_t           r_state;
  logic             r_fault;
  logic [2:0]       r_code;
  logic [1:0]       r_light;
  logic [7:0]       r_cycles;
  logic             r_first;   // current RED is the one entered from SYNC

  lamp_cls_t        w_cls;
  lamp_cls_t        w_same_cls;
  lamp_cls_t        w_next_cls;
  state_t           w_next_st;
  state_t           w_nxt;
  logic [CNT_W-1:0] w_dwell;
  logic [CNT_W-1:0] w_min;
  logic [CNT_W-1:0] w_max;
  logic [2:0]       w_fc;
  logic             w_clr;
  logic             w_load;
  logic             w_inc;
  logic             w_adv;

  assign w_cls = classify(red, yellow, green);

  tlc_dwell_cnt #(.CNT_W(CNT_W)) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_load1 (w_load),
    .i_inc   (w_inc),
    .o_cnt   (w_dwell)
  );

  always_comb begin
    w_same_cls = CL_R;
    w_next_cls = CL_G;
    w_next_st  = ST_GREEN;
    w_min      = R_MIN;
    w_max      = R_MAX;
    case (r_state)
      ST_GREEN: begin
        w_same_cls = CL_G; w_next_cls = CL_Y; w_next_st = ST_YELLOW;
        w_min = G_MIN; w_max = G_MAX;
      end
      ST_YELLOW: begin
        w_same_cls = CL_Y; w_next_cls = CL_R; w_next_st = ST_RED;
        w_min = Y_MIN; w_max = Y_MAX;
      end
      default: ;
    endcase
  end

  // Checks are ordered so the highest-priority cause wins on a sample.
  always_comb begin
    w_fc   = FC_NONE;
    w_clr  = 1'b0;
    w_load = 1'b0;
    w_inc  = 1'b0;
    w_adv  = 1'b0;
    w_nxt  = r_state;
    if (clr_fault) begin
      w_clr = 1'b1;
    end else begin
      case (r_state)
        ST_SYNC: begin
          if (w_cls == CL_CONF) w_fc = FC_CONFLICT;
          else if (w_cls == CL_R) begin
            w_load = 1'b1;
            w_adv  = 1'b1;
            w_nxt  = ST_RED;
          end
        end
        ST_RED, ST_GREEN, ST_YELLOW: begin
          if (w_cls == CL_CONF)           w_fc = FC_CONFLICT;
          else if (w_cls == CL_DARK)      w_fc = FC_DARK;
          else if (w_cls == w_same_cls) begin
            if (w_dwell == w_max)         w_fc = FC_LONG;
            else                          w_inc = 1'b1;
          end else if (w_cls == w_next_cls) begin
            if (w_dwell < w_min && !(r_state == ST_RED && r_first))
              w_fc = FC_SHORT;
            else begin
              w_load = 1'b1;
              w_adv  = 1'b1;
              w_nxt  = w_next_st;
            end
          end else                        w_fc = FC_SEQ;
        end
        default: w_clr = 1'b1;
      endcase
      if (w_fc != FC_NONE) w_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_SYNC;
      r_fault  <= 1'b0;
      r_code   <= FC_NONE;
      r_light  <= LT_NONE;
      r_cycles <= 8'd0;
      r_first  <= 1'b0;
    end else if (clr_fault) begin
      r_state <= ST_SYNC;
      r_fault <= 1'b0;
      r_code  <= FC_NONE;
      r_light <= LT_NONE;
      r_first <= 1'b0;
    end else if (w_fc != FC_NONE) begin
      r_state <= ST_FAULT;
      r_fault <= 1'b1;
      r_code  <= w_fc;
      r_light <= LT_NONE;
      r_first <= 1'b0;
    end else if (w_adv) begin
      r_state <= w_nxt;
      r_light <= light_of(w_nxt);
      r_first <= (r_state == ST_SYNC);
      if (r_state == ST_YELLOW && r_cycles != 8'hFF)
        r_cycles <= r_cycles + 8'd1;
    end
  end

  assign fault      = r_fault;
  assign fault_code = r_code;
  assign cur_light  = r_light;
  assign cycles_ok  = r_cycles;

endmodule

// File: tb/tb_tlc_monitor.sv
// Self-checking bench for tlc_monitor: directed scenarios plus randomized
// lamp sequences compared against a rule-level reference model.
module tb_tlc_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       red = 1'b0, yellow = 1'b0, green = 1'b0, clr_fault = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] cur_light;
  logic [7:0] cycles_ok;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: lamp 0 none, 1 red, 2 green, 3 yellow.
  int m_fault, m_code, m_light, m_dwell, m_first, m_cyc;
  int MN [4] = '{0, 4, 4, 1};
  int MX [4] = '{0, 10, 10, 4};

  tlc_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .clr_fault  (clr_fault),
    .fault      (fault),
    .fault_code (fault_code),
    .cur_light  (cur_light),
    .cycles_ok  (cycles_ok)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_fault = 0; m_code = 0; m_light = 0; m_dwell = 0; m_first = 0; m_cyc = 0;
  endfunction

  function automatic void model_fail(input int c);
    m_fault = 1; m_code = c; m_light = 0; m_dwell = 0; m_first = 0;
  endfunction

  function automatic void model_step(input logic r, input logic y, input logic g, input logic c);
    int nlit, lamp;
    if (c) begin
      m_fault = 0; m_code = 0; m_light = 0; m_dwell = 0; m_first = 0;
      return;
    end
    if (m_fault != 0) return;
    nlit = int'(r) + int'(y) + int'(g);
    lamp = r ? 1 : (g ? 2 : (y ? 3 : 0));
    if (nlit > 1) begin model_fail(2); return; end
    if (m_light == 0) begin
      if (lamp == 1) begin m_light = 1; m_dwell = 1; m_first = 1; end
      return;
    end
    if (nlit == 0) begin model_fail(1); return; end
    if (lamp == m_light) begin
      if (m_dwell + 1 > MX[m_light]) model_fail(5);
      else m_dwell++;
    end else if (lamp == (m_light % 3) + 1) begin
      if (m_dwell < MN[m_light] && !(m_light == 1 && m_first == 1)) model_fail(4);
      else begin
        if (m_light == 3 && m_cyc < 255) m_cyc++;
        m_light = lamp; m_dwell = 1; m_first = 0;
      end
    end else model_fail(3);
  endfunction

  function automatic logic [13:0] mexp();
    return {m_fault[0], m_code[2:0], m_light[1:0], m_cyc[7:0]};
  endfunction

  task automatic step(input logic r, input logic y, input logic g, input logic c);
    @(negedge clk);
    red = r; yellow = y; green = g; clr_fault = c;
    @(posedge clk);
    model_step(r, y, g, c);
    #1;
  endtask

  task automatic drive_n(input logic r, input logic y, input logic g, input int n);
    for (int i = 0; i < n; i++) step(r, y, g, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    red = 0; yellow = 0; green = 0; clr_fault = 0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({fault, fault_code, cur_light, cycles_ok} !== 14'd0)
      $display("FAIL reset: got f=%0b c=%0d l=%0d cyc=%0d, want all 0", fault, fault_code, cur_light, cycles_ok);
    else n_pass++;
  endtask

  task automatic test_legal_cycle();
    logic [1:0] want_l [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
    logic [1:0] got_l  [4];
    do_reset();
    drive_n(1, 0, 0, 6); got_l[0] = cur_light;
    drive_n(0, 0, 1, 6); got_l[1] = cur_light;
    drive_n(0, 1, 0, 2); got_l[2] = cur_light;
    drive_n(1, 0, 0, 1); got_l[3] = cur_light;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (got_l[i] !== want_l[i]) $display("FAIL legal_light[%0d]: got %0d want %0d", i, got_l[i], want_l[i]);
      else n_pass++;
    end
    n_chk++;
    if (fault !== 1'b0 || cycles_ok !== 8'd1)
      $display("FAIL legal_cycle: got f=%0b cyc=%0d want f=0 cyc=1", fault, cycles_ok);
    else n_pass++;
  endtask

  task automatic test_conflict();
    do_reset();
    drive_n(1, 0, 0, 6);
    step(0, 1, 1, 0);
    n_chk++;
    if (fault !== 1'b1 || fault_code !== 3'd2 || cur_light !== 2'd0)
      $display("FAIL conflict: got f=%0b c=%0d l=%0d want f=1 c=2 l=0", fault, fault_code, cur_light);
    else n_pass++;
    drive_n(0, 0, 0, 2); drive_n(1, 0, 0, 3); drive_n(0, 1, 0, 2);
    n_chk++;
    if (fault !== 1'b1 || fault_code !== 3'd2)
      $display("FAIL conflict_hold: got f=%0b c=%0d want f=1 c=2", fault, fault_code);
    else n_pass++;
  endtask

  task automatic test_short();
    do_reset();
    drive_n(1, 0, 0, 6); drive_n(0, 0, 1, 2); drive_n(0, 1, 0, 1);
    n_chk++;
    if (fault !== 1'b1 || fault_code !== 3'd4)
      $display("FAIL short_dwell: got f=%0b c=%0d want f=1 c=4", fault, fault_code);
    else n_pass++;
  endtask

  task automatic test_seq_clear();
    logic [7:0] cyc0;
    do_reset();
    drive_n(1, 0, 0, 6); drive_n(0, 0, 1, 5); drive_n(0, 1, 0, 1); drive_n(1, 0, 0, 5);
    cyc0 = cycles_ok;
    drive_n(0, 1, 0, 1);
    n_chk++;
    if (fault !== 1'b1 || fault_code !== 3'd3)
      $display("FAIL bad_seq: got f=%0b c=%0d want f=1 c=3", fault, fault_code);
    else n_pass++;
    step(0, 1, 1, 1);
    n_chk++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || cur_light !== 2'd0)
      $display("FAIL clear: got f=%0b c=%0d l=%0d want 0 0 0", fault, fault_code, cur_light);
    else n_pass++;
    drive_n(1, 0, 0, 6); drive_n(0, 0, 1, 5);
    n_chk++;
    if (fault !== 1'b0 || cycles_ok !== cyc0 || cycles_ok !== 8'd1 || cur_light !== 2'd2)
      $display("FAIL after_clear: got f=%0b cyc=%0d l=%0d want f=0 cyc=1 l=2", fault, cycles_ok, cur_light);
    else n_pass++;
  endtask

  task automatic test_long();
    do_reset();
    drive_n(1, 0, 0, 10);
    n_chk++;
    if (fault !== 1'b0 || cur_light !== 2'd1)
      $display("FAIL long_edge10: got f=%0b l=%0d want f=0 l=1", fault, cur_light);
    else n_pass++;
    drive_n(1, 0, 0, 1);
    n_chk++;
    if (fault !== 1'b1 || fault_code !== 3'd5)
      $display("FAIL long_dwell: got f=%0b c=%0d want f=1 c=5", fault, fault_code);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_n(1, 0, 0, 6); drive_n(0, 0, 1, 2); drive_n(1, 0, 0, 0);
    drive_n(0, 1, 0, 2); drive_n(1, 0, 0, 5); drive_n(0, 0, 1, 3);
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if ({fault, fault_code, cur_light, cycles_ok} !== 14'd0)
      $display("FAIL async_reset: got f=%0b c=%0d l=%0d cyc=%0d want all 0", fault, fault_code, cur_light, cycles_ok);
    else n_pass++;
    #1 rst = 1'b0;
    model_reset();
    drive_n(0, 0, 0, 3);
    n_chk++;
    if (fault !== 1'b0 || cur_light !== 2'd0)
      $display("FAIL sync_dark: got f=%0b l=%0d want f=0 l=0", fault, cur_light);
    else n_pass++;
    drive_n(1, 0, 0, 1);
    n_chk++;
    if (fault !== 1'b0 || cur_light !== 2'd1)
      $display("FAIL sync_red: got f=%0b l=%0d want f=0 l=1", fault, cur_light);
    else n_pass++;
  endtask

  task automatic test_random();
    int last, lamp, len, v;
    logic [2:0] bits;
    logic c;
    do_reset();
    last = 3;
    for (int s = 0; s < 70; s++) begin
      if (m_fault != 0 && $urandom_range(1) == 1) begin
        step(0, 0, 0, 1);
        last = 3;
      end
      if ($urandom_range(99) < 85) begin
        lamp = (last % 3) + 1;
        bits = (lamp == 1) ? 3'b100 : (lamp == 2) ? 3'b001 : 3'b010;
      end else begin
        v = $urandom_range(7);
        bits = v[2:0];
        lamp = (bits == 3'b100) ? 1 : (bits == 3'b001) ? 2 : (bits == 3'b010) ? 3 : last;
      end
      last = lamp;
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        c = ($urandom_range(99) < 2);
        step(bits[2], bits[1], bits[0], c);
        n_chk++;
        if ({fault, fault_code, cur_light, cycles_ok} !== mexp())
          $display("FAIL random[%0d.%0d]: got f=%0b c=%0d l=%0d cyc=%0d want f=%0d c=%0d l=%0d cyc=%0d",
                   s, j, fault, fault_code, cur_light, cycles_ok, m_fault, m_code, m_light, m_cyc);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_short();
    test_seq_clear();
    test_long();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
